// File: rtl/add_chain_ctrl.sv
// add_chain_ctrl: W-bit add/sub over an external 4-bit adder, one nibble per clock; result NIBBLES cycles after accept.
// Holds DONE while out_ready is low (in_ready low in RUN/DONE); define ADD_CHAIN_SAT_EN to saturate on signed overflow.
module add_chain_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [4*NIBBLES-1:0]   i_op_a,
  input  logic [4*NIBBLES-1:0]   i_op_b,
  input  logic                   i_op_sub,
  output logic [3:0]             o_add_a,
  output logic [3:0]             o_add_b,
  output logic                   o_add_ci,
  input  logic [3:0]             i_add_s,
  input  logic                   i_add_co,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [4*NIBBLES-1:0]   o_result,
  output logic                   o_carry_out,
  output logic                   o_overflow,
  output logic                   o_zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_result;
  logic            r_carry_out;
  logic            r_overflow;
  logic            r_zero;
  logic            r_out_valid;

  logic [W-1:0]    w_res_full;
  logic [W-1:0]    w_res_out;
  logic            w_ovf;

  // Adder is driven only while running so it sees quiet inputs otherwise.
  always_comb begin
    o_add_a  = 4'd0;
    o_add_b  = 4'd0;
    o_add_ci = 1'b0;
    if (r_state == S_RUN) begin
      o_add_a  = r_a[4*r_idx +: 4];
      o_add_b  = r_b[4*r_idx +: 4];
      o_add_ci = r_carry;
    end
  end

  // Partial result with the current nibble merged in; on the last step this is the full sum.
  always_comb begin
    w_res_full                = r_res;
    w_res_full[4*r_idx +: 4]  = i_add_s;
  end

  assign w_ovf = (r_a[W-1] == r_b[W-1]) && (i_add_s[3] != r_a[W-1]);

`ifdef ADD_CHAIN_SAT_EN
  always_comb begin
    w_res_out = w_res_full;
    if (w_ovf) begin
      w_res_out = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_res_out = w_res_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_op_a;
            r_b     <= i_op_sub ? ~i_op_b : i_op_b;
            r_carry <= i_op_sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= w_res_full;
          r_carry <= i_add_co;
          r_idx   <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            r_result    <= w_res_out;
            r_carry_out <= i_add_co;
            r_overflow  <= w_ovf;
            r_zero      <= (w_res_out == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_carry_out = r_carry_out;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;

endmodule
